// File: rtl/checkout_tally.sv
// checkout_tally: scan synchronizer, IDLE/ALARM/LOCK supervisor and saturating checkout tallies.
// Optional build: define TALLY_DUP_FILTER_EN to drop a scan whose upc repeats the last accepted one.
module checkout_tally #(
  parameter int ALARM_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan,
  input  logic [2:0] upc,
  input  logic       mark,
  input  logic       discounted,
  input  logic       stolen,
  input  logic       clear,
  output logic [7:0] item_count,
  output logic [7:0] discount_count,
  output logic [3:0] stolen_count,
  output logic [2:0] last_upc,
  output logic       last_valid,
  output logic       alarm,
  output logic       busy
);

  localparam int tmr_w = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [tmr_w-1:0] tmr_last = tmr_w'(ALARM_CYCLES - 1);
  localparam logic [tmr_w-1:0] tmr_one  = tmr_w'(1);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_alarm = 2'd1,
    st_lock  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [tmr_w-1:0] timer_reg, timer_next;
  logic [3:0]       sync_reg;
  logic [7:0]       item_reg, item_next;
  logic [7:0]       disc_reg, disc_next;
  logic [3:0]       stolen_reg, stolen_next, stolen_inc;
  logic [2:0]       last_upc_reg, last_upc_next;
  logic             last_valid_reg, last_valid_next;
  logic             scan_event, dup_hit, accept;
  logic             unused_mark;

  // mark only matters to the UPC stage
  assign unused_mark = mark;

  // [0],[1] synchronize; [2],[3] remember the last two synchronized samples so that
  // an event needs scan low for two cycles before it rises again
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 4'b0000;
    end else begin
      sync_reg <= {sync_reg[2:0], scan};
    end
  end

  assign scan_event = sync_reg[1] & ~sync_reg[2] & ~sync_reg[3];

`ifdef TALLY_DUP_FILTER_EN
  assign dup_hit = last_valid_reg && (upc == last_upc_reg);
`else
  assign dup_hit = 1'b0;
`endif

  assign accept     = scan_event && (state_reg == st_idle) && !clear && !dup_hit;
  assign stolen_inc = (stolen_reg == 4'hf) ? 4'hf : stolen_reg + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= st_idle;
      timer_reg <= '0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = st_idle;
    end else begin
      case (state_reg)
        st_idle: begin
          if (accept && stolen) begin
            state_next = (stolen_inc == 4'hf) ? st_lock : st_alarm;
          end
        end
        st_alarm: begin
          if (timer_reg == tmr_last) begin
            state_next = st_idle;
          end
        end
        st_lock:  state_next = st_lock;
        default:  state_next = st_idle;
      endcase
    end
  end

  // timer restarts from zero on every entry into ALARM
  always_comb begin
    timer_next = '0;
    if (!clear && (state_reg == st_alarm) && (state_next == st_alarm)) begin
      timer_next = timer_reg + tmr_one;
    end
  end

  always_comb begin
    alarm = 1'b0;
    busy  = 1'b0;
    case (state_reg)
      st_alarm: begin
        alarm = 1'b1;
        busy  = 1'b1;
      end
      st_lock: begin
        alarm = 1'b1;
        busy  = 1'b1;
      end
      default: begin
        alarm = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  // stolen wins over discounted; item and discount tallies saturate
  always_comb begin
    item_next       = item_reg;
    disc_next       = disc_reg;
    stolen_next     = stolen_reg;
    last_upc_next   = last_upc_reg;
    last_valid_next = last_valid_reg;
    if (clear) begin
      item_next       = 8'd0;
      disc_next       = 8'd0;
      stolen_next     = 4'd0;
      last_upc_next   = 3'd0;
      last_valid_next = 1'b0;
    end else if (accept) begin
      last_upc_next   = upc;
      last_valid_next = 1'b1;
      if (stolen) begin
        stolen_next = stolen_inc;
      end else begin
        if (item_reg != 8'hff) begin
          item_next = item_reg + 8'd1;
        end
        if (discounted && (disc_reg != 8'hff)) begin
          disc_next = disc_reg + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      item_reg       <= 8'd0;
      disc_reg       <= 8'd0;
      stolen_reg     <= 4'd0;
      last_upc_reg   <= 3'd0;
      last_valid_reg <= 1'b0;
    end else begin
      item_reg       <= item_next;
      disc_reg       <= disc_next;
      stolen_reg     <= stolen_next;
      last_upc_reg   <= last_upc_next;
      last_valid_reg <= last_valid_next;
    end
  end

  assign item_count     = item_reg;
  assign discount_count = disc_reg;
  assign stolen_count   = stolen_reg;
  assign last_upc       = last_upc_reg;
  assign last_valid     = last_valid_reg;

endmodule

// File: doc/checkout_tally.md
CHECKOUT_TALLY -- requirements
Module: checkout_tally

Interface
REQ-001 Parameter ALARM_CYCLES, default 50_000_000, SHALL set the alarm hold time in clk cycles (one second at 50 MHz).
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 reset_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 scan  input  1  SHALL be the raw, asynchronous, active-high scan request (inverted pushbutton).
REQ-005 upc  input  3  SHALL be the item code from the UPC decode stage.
REQ-006 mark  input  1  SHALL be the previously-purchased mark.
REQ-007 discounted  input  1  SHALL be the UPC stage discounted flag.
REQ-008 stolen  input  1  SHALL be the UPC stage stolen flag.
REQ-009 clear  input  1  SHALL be a synchronous, active-high tally clear.
REQ-010 item_count  output  8  SHALL be the number of accepted non-stolen scans.
REQ-011 discount_count  output  8  SHALL be the number of accepted discounted scans.
REQ-012 stolen_count  output  4  SHALL be the number of accepted stolen scans.
REQ-013 last_upc  output  3  SHALL be the upc of the last accepted scan.
REQ-014 last_valid  output  1  SHALL be high once any scan has been accepted since reset or clear.
REQ-015 alarm  output  1  SHALL be high in states ALARM and LOCK.
REQ-016 busy  output  1  SHALL be high in any state other than IDLE.

Function
REQ-017 scan SHALL pass through a two-flop synchronizer; a scan event SHALL be sync2 high while the previous sync2 value was low.
REQ-018 Scan event latency SHALL be fixed: counters, last_upc and last_valid update on the 3rd rising clk edge counting the first edge that samples scan high.
REQ-019 upc, mark, discounted and stolen SHALL be sampled in the cycle the scan event is detected; upstream holds them stable while scan is high.
REQ-020 The FSM SHALL have states IDLE, ALARM and LOCK; scan events SHALL be accepted only in IDLE.
REQ-021 An IDLE scan with stolen=1 SHALL increment stolen_count, SHALL NOT touch item_count or discount_count, and SHALL go to ALARM, or to LOCK if stolen_count reaches 15.
REQ-022 An IDLE scan with stolen=0 SHALL increment item_count, and also discount_count if discounted=1, and SHALL stay in IDLE.
REQ-023 stolen=1 SHALL take priority over discounted=1 when both are set.
REQ-024 mark SHALL NOT affect counting; it is consumed only by the UPC stage.
REQ-025 ALARM SHALL last exactly ALARM_CYCLES cycles, then return to IDLE; scan events during ALARM SHALL be discarded, not queued.
REQ-026 LOCK SHALL persist until clear or reset.
REQ-027 item_count and discount_count SHALL saturate at 255 and never wrap.
REQ-028 clear SHALL zero all counts and last_valid, zero last_upc, go to IDLE next cycle, and reset the alarm timer.
REQ-029 clear SHALL win over a scan event in the same cycle; that scan SHALL be discarded.
REQ-030 A scan held high SHALL produce exactly one event; a new event SHALL require scan to be low for at least 2 cycles first.

Reset
REQ-031 While reset_n is low, all outputs SHALL be 0, the state SHALL be IDLE, and the synchronizer and alarm timer SHALL be 0, independent of clk.
REQ-032 Reset asserted mid-ALARM or mid-LOCK SHALL drop alarm asynchronously; after release the block SHALL be in IDLE with no pending event.

Configuration
REQ-033 With TALLY_DUP_FILTER_EN defined, a scan event SHALL be discarded, with no count and no state change, when last_valid=1 and upc equals last_upc.
REQ-034 Without TALLY_DUP_FILTER_EN, every IDLE scan event SHALL be processed per REQ-021 and REQ-022.

Verification (ALARM_CYCLES=8)
REQ-035 Reset, then scan upc=3'b010, discounted=1, stolen=0 -> item_count=1, discount_count=1, last_upc=2, last_valid=1, on the 3rd edge.
REQ-036 Scan stolen=1, then scan again 3 cycles later -> stolen_count=1, alarm high for exactly 8 cycles, second scan ignored.
REQ-037 Fifteen stolen scans spaced beyond the alarm time -> stolen_count=15, state LOCK, alarm stays high; clear -> counts 0, alarm low next cycle.
REQ-038 260 non-stolen scans -> item_count=255, no wrap.
REQ-039 clear asserted in the same cycle as a scan event -> all counts remain 0.
REQ-040 With TALLY_DUP_FILTER_EN, scan upc=5 twice then upc=6 -> item_count=2; without the macro -> item_count=3.
